// File: rtl/beea_sched.sv
// Round-robin scheduler sharing one beea modular-inverse engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining BEEA_SCHED_TIMEOUT_EN.
module beea_sched #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_k,
  input  logic [NUM_REQ*WIDTH-1:0]   req_p,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_k,
  output logic [WIDTH-1:0]           eng_p,
  input  logic                       eng_rdy,
  input  logic [WIDTH-1:0]           eng_c
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW:0]     idx;
  logic             found;
  logic             grant;
  logic             bad_op;
  logic             saw_busy;
  logic             tmo_hit;
  logic [WIDTH-1:0] win_k, win_p;

  // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (IDW+1)'(rr_ptr) + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  assign win_k  = req_k[winner*WIDTH +: WIDTH];
  assign win_p  = req_p[winner*WIDTH +: WIDTH];
  assign grant  = (state == IDLE) && eng_rdy && found;
  assign bad_op = (win_k == '0) || (win_p < WIDTH'(2)) || (win_k >= win_p);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign eng_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);

`ifdef BEEA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) tmo_cnt <= '0;
    else if (state == WAIT)    tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = bad_op ? RESP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if ((saw_busy && eng_rdy) || tmo_hit) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      saw_busy <= 1'b0;
      eng_k    <= '0;
      eng_p    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (grant) begin
          eng_k    <= win_k;
          eng_p    <= win_p;
          rsp_id   <= winner;
          rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          rsp_data <= '0;
          rsp_err  <= bad_op;
        end
        ISSUE: saw_busy <= 1'b0;
        WAIT: begin
          // rdy still high from the previous run is ignored until the engine has dropped it.
          if (!eng_rdy) saw_busy <= 1'b1;
          if (saw_busy && eng_rdy) begin
            rsp_data <= eng_c;
            rsp_err  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
